// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: turns one EXU load/store into an aligned 64-bit data-memory access.
// Optional misaligned-access trap enabled by defining YSYX_22050243_LSU_MISALIGN_TRAP_EN.
module ysyx_22050243_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [7:0]        mem_wmask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic              wen_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              trap_in;

    logic [2:0]        off;
    logic [5:0]        sh_amt;
    logic [7:0]        size_mask;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ld_data;

    assign off    = addr_q[2:0];
    assign sh_amt = {off, 3'b000};
    assign sh     = mem_rdata >> sh_amt;

`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
    logic err_q;
    // Misaligned when the offset is not a multiple of the access size.
    always_comb begin
        trap_in = 1'b0;
        case (req_funct3[1:0])
            2'd0: trap_in = 1'b0;
            2'd1: trap_in = req_addr[0];
            2'd2: trap_in = |req_addr[1:0];
            2'd3: trap_in = |req_addr[2:0];
            default: trap_in = 1'b0;
        endcase
    end
    assign resp_err = err_q;
`else
    assign trap_in  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_comb begin
        size_mask = 8'h01;
        case (f3_q[1:0])
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
            default: size_mask = 8'h01;
        endcase
    end

    always_comb begin
        ld_data = sh;
        case (f3_q)
            3'b000: ld_data = {{56{sh[7]}}, sh[7:0]};
            3'b001: ld_data = {{48{sh[15]}}, sh[15:0]};
            3'b010: ld_data = {{32{sh[31]}}, sh[31:0]};
            3'b100: ld_data = {56'd0, sh[7:0]};
            3'b101: ld_data = {48'd0, sh[15:0]};
            3'b110: ld_data = {32'd0, sh[31:0]};
            default: ld_data = sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_valid  = 1'b0;
        mem_wen    = 1'b0;
        mem_wmask  = 8'h00;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = trap_in ? RESP : REQ;
            end
            REQ: begin
                // All mem_* derive from captured registers, so they hold while stalled.
                mem_valid = 1'b1;
                mem_wen   = wen_q;
                mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
                if (wen_q) begin
                    mem_wmask = size_mask << off;
                    mem_wdata = wdata_q << sh_amt;
                end
                if (mem_ready) state_nxt = wen_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q      <= 1'b0;
            f3_q       <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            if (state == IDLE && req_valid) begin
                wen_q      <= req_wen;
                f3_q       <= req_funct3;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                resp_rdata <= '0;
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
                err_q      <= trap_in;
`endif
            end
            if (state == WAIT && mem_rvalid) resp_rdata <= ld_data;
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
            if (state == RESP && resp_ready) err_q <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Self-checking bench for ysyx_22050243_lsu: directed cases plus randomized
// accesses compared against a byte-level reference model.
module tb_ysyx_22050243_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_wen;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050243_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference model: byte-by-byte view of the access within one doubleword.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] model_mask(input logic [2:0] f3, input logic [63:0] addr);
        logic [7:0] m = 8'h00;
        int off = int'(addr[2:0]);
        for (int b = 0; b < size_of(f3); b++)
            if (off + b < 8) m[off + b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [2:0] f3, input logic [63:0] addr,
                                                input logic [63:0] wd);
        logic [63:0] r = '0;
        int off = int'(addr[2:0]);
        for (int b = 0; b < size_of(f3); b++)
            if (off + b < 8) r[8*(off+b) +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                               input logic [63:0] rd);
        logic [63:0] v = '0;
        int off = int'(addr[2:0]);
        int sz  = size_of(f3);
        for (int b = 0; b < sz; b++)
            if (off + b < 8) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if (!f3[2] && sz < 8 && v[8*sz-1])
            v = v | ~((64'd1 << (8*sz)) - 64'd1);
        return v;
    endfunction

    function automatic bit model_trap(input logic [2:0] f3, input logic [63:0] addr);
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
        return (int'(addr[2:0]) % size_of(f3)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction; the bench plays the memory and WBU.
    task automatic run(input bit wen, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd,
                       input int rdly, input int vdly, input int pdly,
                       output int lat, output logic [63:0] got_rdata,
                       output logic got_err, output bit saw_mem);
        bit trap = model_trap(f3, addr);
        logic [63:0] exp_r = (wen || trap) ? 64'd0 : model_load(f3, addr, rd);
        saw_mem = 1'b0;
        @(negedge clk);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0; req_wdata = $urandom; req_addr = {$urandom, $urandom};
        lat = 1;
        check("req_ready_busy", 64'(req_ready), 64'd0);
        if (!trap) begin
            for (int c = 0; c <= rdly; c++) begin
                if (mem_valid) saw_mem = 1'b1;
                check("mem_valid", 64'(mem_valid), 64'd1);
                check("mem_addr", mem_addr, {addr[63:3], 3'b000});
                check("mem_wen", 64'(mem_wen), 64'(wen));
                check("mem_wmask", 64'(mem_wmask), wen ? 64'(model_mask(f3, addr)) : 64'd0);
                if (wen) check("mem_wdata", mem_wdata, model_wdata(f3, addr, wd));
                check("req_ready_req", 64'(req_ready), 64'd0);
                if (c < rdly) begin @(negedge clk); lat++; end
            end
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0; lat++;
            if (!wen) begin
                check("mem_valid_wait", 64'(mem_valid), 64'd0);
                repeat (vdly) begin
                    @(negedge clk); lat++;
                    check("no_resp_wait", 64'(resp_valid), 64'd0);
                end
                mem_rvalid = 1'b1; mem_rdata = rd;
                @(negedge clk);
                mem_rvalid = 1'b0; mem_rdata = $urandom; lat++;
            end
        end else begin
            check("mem_valid_trap", 64'(mem_valid), 64'd0);
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_rdata", resp_rdata, exp_r);
        check("resp_err", 64'(resp_err), 64'(trap));
        got_rdata = resp_rdata; got_err = resp_err;
        repeat (pdly) begin
            @(negedge clk);
            check("resp_hold_v", 64'(resp_valid), 64'd1);
            check("resp_hold_d", resp_rdata, exp_r);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_clear", 64'(resp_valid), 64'd0);
        check("resp_err_clear", 64'(resp_err), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int lat;
        logic [63:0] r;
        logic e;
        bit sm;
        localparam logic [63:0] RD = 64'h8877665544332211;

        rst_n = 1'b0; req_valid = 0; req_wen = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; resp_ready = 0;
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_wmask", 64'(mem_wmask), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        run(0, 3'b100, 64'h80000003, 0, RD, 0, 0, 0, lat, r, e, sm);
        check("lbu_data", r, 64'h44);
        check("lbu_lat", 64'(lat), 64'd3);
        run(0, 3'b000, 64'h80000007, 0, RD, 0, 0, 1, lat, r, e, sm);
        check("lb_data", r, 64'hFFFFFFFFFFFFFF88);
        run(1, 3'b001, 64'h80000006, 64'h1234, RD, 0, 0, 0, lat, r, e, sm);
        check("sh_lat", 64'(lat), 64'd2);
        check("sh_rdata", r, 64'd0);
        run(1, 3'b011, 64'h80000008, 64'hDEADBEEFCAFEF00D, RD, 3, 0, 0, lat, r, e, sm);
        check("sd_lat", 64'(lat), 64'd5);
        run(0, 3'b010, 64'h80000002, 0, RD, 0, 0, 0, lat, r, e, sm);
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
        check("lw_mis_err", 64'(e), 64'd1);
        check("lw_mis_nomem", 64'(sm), 64'd0);
`else
        check("lw_mis_data", r, 64'h0000000066554433);
`endif

        // Reset during WAIT abandons the load; a late rvalid must not respond.
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_funct3 = 3'b011; req_addr = 64'h80000010;
        @(negedge clk); req_valid = 0; mem_ready = 1;
        @(negedge clk); mem_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_mem_valid", 64'(mem_valid), 64'd0);
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_resp_rdata", resp_rdata, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        mem_rvalid = 1; mem_rdata = RD;
        @(negedge clk); mem_rvalid = 0;
        repeat (2) begin
            check("late_rvalid", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end
        run(0, 3'b011, 64'h80000018, 0, RD, 0, 1, 0, lat, r, e, sm);
        check("ld_after_rst", r, RD);

        for (int i = 0; i < 60; i++) begin
            bit w = 1'($urandom_range(0, 1));
            logic [2:0] f = w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            logic [63:0] a = 64'h80000000 + 64'($urandom_range(0, 255));
            run(w, f, a, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                lat, r, e, sm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
